// File: rtl/scr1_dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scr1_dmem_responder_pkg
// Description : Shared types and helpers for the SCR1 memory-interface
//               responders. It holds the memif command/width/response enums,
//               the width-to-byte-enable helper, the alignment helper and
//               the maximum response latency.
// Revision    : 1.0 - initial release
// ============================================================================
package scr1_dmem_responder_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    // Longest supported accept-to-response distance, in cycles
    localparam int SCR1_DMEM_RESP_LAT_MAX = 4;

    // Byte enables of an access of the given width starting at byte offset
    function automatic logic [3:0] scr1_width_to_be(
        input type_scr1_mem_width_e width,
        input logic [1:0]           offset
    );
        logic [3:0] be;
        case (width)
            SCR1_MEM_WIDTH_BYTE:  be = 4'b0001 << offset;
            SCR1_MEM_WIDTH_HWORD: be = 4'b0011 << offset;
            SCR1_MEM_WIDTH_WORD:  be = 4'b1111;
            default:              be = 4'b0000;
        endcase
        return be;
    endfunction

    // Natural alignment check; the reserved width encoding is never aligned
    function automatic logic scr1_mem_aligned(
        input type_scr1_mem_width_e width,
        input logic [1:0]           offset
    );
        logic ok;
        case (width)
            SCR1_MEM_WIDTH_BYTE:  ok = 1'b1;
            SCR1_MEM_WIDTH_HWORD: ok = ~offset[0];
            SCR1_MEM_WIDTH_WORD:  ok = (offset == 2'b00);
            default:              ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage : scr1_dmem_responder_pkg
`default_nettype wire

// File: rtl/scr1_mem_lane_steer.sv
`default_nettype none
// ============================================================================
// Module      : scr1_mem_lane_steer
// Description : Purely combinational byte-lane steering for a 32-bit memory
//               port. The request side produces byte enables and the
//               lane-placed write data. The response side extracts
//               right-aligned, zero-extended read data. The two sides take
//               independent width/offset inputs because they belong to
//               different transactions when accepts are back-to-back.
// Ports       : req_width/req_offset/req_wdata -> req_be, req_wdata_lane
//               rsp_width/rsp_offset/rsp_rdata -> rsp_data
// Revision    : 1.0 - initial release
// ============================================================================
module scr1_mem_lane_steer
    import scr1_dmem_responder_pkg::*;
(
    input  type_scr1_mem_width_e req_width,
    input  logic [1:0]           req_offset,
    input  logic [31:0]          req_wdata,
    output logic [3:0]           req_be,
    output logic [31:0]          req_wdata_lane,
    input  type_scr1_mem_width_e rsp_width,
    input  logic [1:0]           rsp_offset,
    input  logic [31:0]          rsp_rdata,
    output logic [31:0]          rsp_data
);

    logic [4:0]  w_req_shift;
    logic [4:0]  w_rsp_shift;
    logic [31:0] w_rsp_shifted;

    assign w_req_shift    = {req_offset, 3'b000};
    assign w_rsp_shift    = {rsp_offset, 3'b000};

    assign req_be         = scr1_width_to_be(req_width, req_offset);
    assign req_wdata_lane = req_wdata << w_req_shift;

    assign w_rsp_shifted  = rsp_rdata >> w_rsp_shift;

    always_comb begin
        rsp_data = w_rsp_shifted;
        case (rsp_width)
            SCR1_MEM_WIDTH_BYTE:  rsp_data = {24'h0, w_rsp_shifted[7:0]};
            SCR1_MEM_WIDTH_HWORD: rsp_data = {16'h0, w_rsp_shifted[15:0]};
            default:              rsp_data = w_rsp_shifted;
        endcase
    end

endmodule : scr1_mem_lane_steer
`default_nettype wire

// File: rtl/scr1_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : scr1_dmem_responder
// Description : Target endpoint of the SCR1 data-memory interface in front of
//               a single-port synchronous SRAM. It accepts one request at a
//               time and checks window range and alignment. It drives the
//               SRAM in the accept cycle and presents a one-cycle response
//               exactly RESP_LATENCY cycles after the accept edge.
// Ports       : clk, rst_n (async, active-low)
//               dmem_req/dmem_req_ack/dmem_cmd/dmem_width/dmem_addr/
//               dmem_wdata  - request side
//               dmem_rdata/dmem_resp - response side
//               sram_cs/we/be/addr/wdata/rdata - SRAM port (1-cycle read)
// Revision    : 1.0 - initial release
// ============================================================================
module scr1_dmem_responder
    import scr1_dmem_responder_pkg::*;
#(
    parameter int          SRAM_AWIDTH  = 12,
    parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
    parameter int          RESP_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dmem_req,
    output logic                   dmem_req_ack,
    input  type_scr1_mem_cmd_e     dmem_cmd,
    input  type_scr1_mem_width_e   dmem_width,
    input  logic [31:0]            dmem_addr,
    input  logic [31:0]            dmem_wdata,
    output logic [31:0]            dmem_rdata,
    output type_scr1_mem_resp_e    dmem_resp,
    output logic                   sram_cs,
    output logic                   sram_we,
    output logic [3:0]             sram_be,
    output logic [SRAM_AWIDTH-1:0] sram_addr,
    output logic [31:0]            sram_wdata,
    input  logic [31:0]            sram_rdata
);

    localparam int c_cnt_w = $clog2(SCR1_DMEM_RESP_LAT_MAX);
    localparam logic [c_cnt_w-1:0] c_lat_init = c_cnt_w'(RESP_LATENCY - 1);
    // Clears the in-window byte offset so the remainder compares to the base
    localparam logic [31:0] c_win_mask = ~((32'd1 << (SRAM_AWIDTH + 2)) - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    type_scr1_mem_cmd_e   r_cmd;
    type_scr1_mem_width_e r_width;
    logic [1:0]           r_off;
    logic                 r_err;

    logic        w_in_range;
    logic        w_aligned;
    logic        w_good;
    logic        w_accept;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_lane;
    logic [31:0] w_rsp_raw;
    logic [31:0] w_rsp_data;

    // Request qualification
    assign w_in_range = ((dmem_addr & c_win_mask) == BASE_ADDR);
    assign w_aligned  = scr1_mem_aligned(dmem_width, dmem_addr[1:0]);
    assign w_good     = w_in_range & w_aligned;

    // Gating with rst_n keeps the acknowledge low while reset is held,
    // even though the state register already sits in IDLE.
    assign w_accept     = rst_n & dmem_req & ((r_state == ST_IDLE) | (r_state == ST_RESP));
    assign dmem_req_ack = w_accept;

    scr1_mem_lane_steer u_lane_steer (
        .req_width      (dmem_width),
        .req_offset     (dmem_addr[1:0]),
        .req_wdata      (dmem_wdata),
        .req_be         (w_be),
        .req_wdata_lane (w_wdata_lane),
        .rsp_width      (r_width),
        .rsp_offset     (r_off),
        .rsp_rdata      (w_rsp_raw),
        .rsp_data       (w_rsp_data)
    );

    // SRAM access only happens in the accept cycle of a good request
    assign sram_cs    = w_accept & w_good;
    assign sram_we    = w_accept & w_good & (dmem_cmd == SCR1_MEM_CMD_WR);
    assign sram_be    = (w_accept & w_good) ? w_be : 4'b0000;
    assign sram_addr  = dmem_addr[SRAM_AWIDTH+1:2];
    assign sram_wdata = w_wdata_lane;

    // With latency 1 the response cycle is the SRAM data cycle itself.
    // Longer latencies hold the word captured one cycle after the accept,
    // because the SRAM output is not guaranteed to stay stable afterwards.
    generate
        if (RESP_LATENCY == 1) begin : g_rdata_direct
            assign w_rsp_raw = sram_rdata;
        end else begin : g_rdata_captured
            logic        r_cap_en;
            logic [31:0] r_rdata_cap;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cap_en    <= 1'b0;
                    r_rdata_cap <= 32'h0;
                end else begin
                    r_cap_en <= w_accept;
                    if (r_cap_en) begin
                        r_rdata_cap <= sram_rdata;
                    end
                end
            end

            assign w_rsp_raw = r_rdata_cap;
        end
    endgenerate

    // Transaction FSM and latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cmd   <= SCR1_MEM_CMD_RD;
            r_width <= SCR1_MEM_WIDTH_BYTE;
            r_off   <= 2'b00;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_accept) begin
                        r_cmd   <= dmem_cmd;
                        r_width <= dmem_width;
                        r_off   <= dmem_addr[1:0];
                        r_err   <= ~w_good;
                        r_cnt   <= c_lat_init;
                        r_state <= (c_lat_init == '0) ? ST_RESP : ST_WAIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_state <= ST_RESP;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Response is decoded from registered state only
    always_comb begin
        dmem_resp  = SCR1_MEM_RESP_NOTRDY;
        dmem_rdata = 32'h0;
        if (r_state == ST_RESP) begin
            dmem_resp = r_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            if (!r_err && (r_cmd == SCR1_MEM_CMD_RD)) begin
                dmem_rdata = w_rsp_data;
            end
        end
    end

endmodule : scr1_dmem_responder
`default_nettype wire

// File: tb/tb_scr1_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_scr1_dmem_responder
// Description : Self-checking bench for scr1_dmem_responder. One instance
//               uses latency 1 and runs directed and random traffic against a
//               byte-array scoreboard. A second instance uses latency 3 and
//               covers back-to-back pipelining and reset in the middle of a
//               transaction.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_scr1_dmem_responder;
    import scr1_dmem_responder_pkg::*;

    localparam logic [31:0] c_base      = 32'h0001_0000;
    localparam int          c_win_bytes = 16384;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- latency-1 instance ----------------
    logic                 rst_n1;
    logic                 req1;
    logic                 ack1;
    type_scr1_mem_cmd_e   cmd1;
    type_scr1_mem_width_e width1;
    logic [31:0]          addr1, wdata1, rdata1;
    type_scr1_mem_resp_e  resp1;
    logic                 cs1, we1;
    logic [3:0]           be1;
    logic [11:0]          saddr1;
    logic [31:0]          swdata1;
    logic [31:0]          srdata1 = 32'h0;
    logic [31:0]          mem1 [0:4095] = '{default: 32'h0};
    logic [7:0]           sb   [0:c_win_bytes-1] = '{default: 8'h00};

    scr1_dmem_responder #(.SRAM_AWIDTH(12), .BASE_ADDR(c_base), .RESP_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .dmem_req(req1), .dmem_req_ack(ack1),
        .dmem_cmd(cmd1), .dmem_width(width1), .dmem_addr(addr1), .dmem_wdata(wdata1),
        .dmem_rdata(rdata1), .dmem_resp(resp1), .sram_cs(cs1), .sram_we(we1),
        .sram_be(be1), .sram_addr(saddr1), .sram_wdata(swdata1), .sram_rdata(srdata1)
    );

    always @(posedge clk) begin
        if (cs1) begin
            if (we1) begin
                for (int b = 0; b < 4; b++)
                    if (be1[b]) mem1[saddr1][8*b +: 8] <= swdata1[8*b +: 8];
            end else begin
                srdata1 <= mem1[saddr1];
            end
        end
    end

    // ---------------- latency-3 instance ----------------
    logic                 rst_n3;
    logic                 req3;
    logic                 ack3;
    type_scr1_mem_cmd_e   cmd3;
    type_scr1_mem_width_e width3;
    logic [31:0]          addr3, rdata3;
    logic [31:0]          wdata3 = 32'h0;
    type_scr1_mem_resp_e  resp3;
    logic                 cs3, we3;
    logic [3:0]           be3;
    logic [11:0]          saddr3;
    logic [31:0]          swdata3;
    logic [31:0]          srdata3 = 32'h0;
    logic [31:0]          mem3 [0:4095] = '{0: 32'hA000_0000, 1: 32'hA000_0001,
                                            2: 32'hA000_0002, 3: 32'hA000_0003,
                                            default: 32'h0};

    scr1_dmem_responder #(.SRAM_AWIDTH(12), .BASE_ADDR(c_base), .RESP_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n3), .dmem_req(req3), .dmem_req_ack(ack3),
        .dmem_cmd(cmd3), .dmem_width(width3), .dmem_addr(addr3), .dmem_wdata(wdata3),
        .dmem_rdata(rdata3), .dmem_resp(resp3), .sram_cs(cs3), .sram_we(we3),
        .sram_be(be3), .sram_addr(saddr3), .sram_wdata(swdata3), .sram_rdata(srdata3)
    );

    always @(posedge clk) begin
        if (cs3 && !we3) srdata3 <= mem3[saddr3];
    end

    // One transaction on the latency-1 instance, checked against the scoreboard
    task automatic txn(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e width,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] o_rdata, output logic [3:0] o_be,
                       output logic o_cs, output logic [31:0] o_swdata,
                       output type_scr1_mem_resp_e o_resp);
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [3:0]  exp_be;
        int          nb, off, lat;
        nb      = (width == SCR1_MEM_WIDTH_BYTE) ? 1 : (width == SCR1_MEM_WIDTH_HWORD) ? 2 : 4;
        exp_err = !((addr >= c_base) && (addr < c_base + c_win_bytes)) ||
                  ((width == SCR1_MEM_WIDTH_HWORD) && addr[0]) ||
                  ((width == SCR1_MEM_WIDTH_WORD) && (addr[1:0] != 2'b00));
        exp_rd  = 32'h0;
        exp_be  = 4'b0000;
        off     = 0;
        if (!exp_err) begin
            off = int'(addr - c_base);
            for (int i = 0; i < nb; i++) begin
                exp_be[int'(addr[1:0]) + i] = 1'b1;
                if (cmd == SCR1_MEM_CMD_RD) exp_rd[8*i +: 8] = sb[off + i];
            end
        end
        @(posedge clk); #1;
        req1 = 1'b1; cmd1 = cmd; width1 = width; addr1 = addr; wdata1 = wdata;
        @(negedge clk);
        chk("ack", 32'(ack1), 32'd1);
        chk("cs", 32'(cs1), 32'(!exp_err));
        if (!exp_err) begin
            chk("we", 32'(we1), 32'(cmd == SCR1_MEM_CMD_WR));
            chk("be", 32'(be1), 32'(exp_be));
        end
        o_be = be1; o_cs = cs1; o_swdata = swdata1;
        @(posedge clk); #1;
        req1 = 1'b0;
        lat = 1;
        @(negedge clk);
        while (resp1 == SCR1_MEM_RESP_NOTRDY && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd1);
        chk("resp", 32'(resp1), 32'(exp_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK));
        chk("rdata", rdata1, exp_rd);
        o_rdata = rdata1;
        o_resp  = resp1;
        if (!exp_err && cmd == SCR1_MEM_CMD_WR)
            for (int i = 0; i < nb; i++) sb[off + i] = wdata[8*i +: 8];
    endtask

    initial begin
        logic [31:0]          rd, sw, ra;
        logic [3:0]           be;
        logic                 cs, a;
        type_scr1_mem_resp_e  rs;
        type_scr1_mem_cmd_e   rc;
        type_scr1_mem_width_e rw;
        int                   nacc, nresp, lat;

        rst_n1 = 1'b0; rst_n3 = 1'b0;
        req1 = 1'b1; cmd1 = SCR1_MEM_CMD_RD; width1 = SCR1_MEM_WIDTH_WORD; addr1 = c_base; wdata1 = 32'h0;
        req3 = 1'b0; cmd3 = SCR1_MEM_CMD_RD; width3 = SCR1_MEM_WIDTH_WORD; addr3 = c_base;
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack1), 32'd0);
        chk("rst_resp", 32'(resp1), 32'(SCR1_MEM_RESP_NOTRDY));
        chk("rst_rdata", rdata1, 32'h0);
        chk("rst_cs", 32'(cs1), 32'd0);
        chk("rst_we", 32'(we1), 32'd0);
        chk("rst_be", 32'(be1), 32'd0);
        @(posedge clk); #1;
        rst_n1 = 1'b1; rst_n3 = 1'b1; req1 = 1'b0;

        // Directed, latency 1
        txn(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h0001_0008, 32'hDEADBEEF, rd, be, cs, sw, rs);
        chk("wr_word_be", 32'(be), 32'hF);
        txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0001_0008, 32'h0, rd, be, cs, sw, rs);
        chk("rd_word_data", rd, 32'hDEADBEEF);
        txn(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h0001_0003, 32'h0000_00A5, rd, be, cs, sw, rs);
        chk("wr_byte_be", 32'(be), 32'h8);
        chk("wr_byte_lane", 32'(sw[31:24]), 32'hA5);
        txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h0001_0003, 32'h0, rd, be, cs, sw, rs);
        chk("rd_byte_data", rd, 32'h0000_00A5);
        txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0001_0000, 32'h0, rd, be, cs, sw, rs);
        chk("rd_word0_data", rd, 32'hA500_0000);
        txn(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h0001_000A, 32'h0000_1234, rd, be, cs, sw, rs);
        chk("wr_hword_be", 32'(be), 32'hC);
        chk("wr_hword_lane", 32'(sw[31:16]), 32'h1234);
        txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0001_0008, 32'h0, rd, be, cs, sw, rs);
        chk("rd_merge_data", rd, 32'h1234BEEF);
        txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h0001_0001, 32'h0, rd, be, cs, sw, rs);
        chk("mis_cs", 32'(cs), 32'd0);
        chk("mis_resp", 32'(rs), 32'(SCR1_MEM_RESP_RDY_ER));
        chk("mis_rdata", rd, 32'h0);
        txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0002_0000, 32'h0, rd, be, cs, sw, rs);
        chk("oor_cs", 32'(cs), 32'd0);
        chk("oor_resp", 32'(rs), 32'(SCR1_MEM_RESP_RDY_ER));

        // Random traffic against the scoreboard
        for (int t = 0; t < 10000; t++) begin
            rc = ($urandom_range(0, 1) == 1) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
            case ($urandom_range(0, 2))
                0:       rw = SCR1_MEM_WIDTH_BYTE;
                1:       rw = SCR1_MEM_WIDTH_HWORD;
                default: rw = SCR1_MEM_WIDTH_WORD;
            endcase
            if ($urandom_range(0, 9) == 0) ra = $urandom;
            else                           ra = c_base + 32'($urandom_range(0, c_win_bytes - 1));
            txn(rc, rw, ra, $urandom, rd, be, cs, sw, rs);
        end

        // Latency 3: continuous request, four reads
        @(posedge clk); #1;
        req3 = 1'b1; addr3 = c_base; nacc = 0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            a = ack3;
            chk("p_ack", 32'(ack3), 32'((c % 3 == 0) && (c <= 9)));
            chk("p_resp", 32'(resp3), 32'(((c % 3 == 0) && (c >= 3)) ? SCR1_MEM_RESP_RDY_OK
                                                                      : SCR1_MEM_RESP_NOTRDY));
            if ((c % 3 == 0) && (c >= 3))
                chk("p_rdata", rdata3, 32'hA000_0000 + 32'(c / 3 - 1));
            @(posedge clk); #1;
            if (a) begin
                nacc++;
                if (nacc == 4) req3 = 1'b0;
                else           addr3 = c_base + 32'(4 * nacc);
            end
        end

        // Latency 3: reset while waiting on a read
        @(posedge clk); #1;
        req3 = 1'b1; addr3 = c_base + 32'd4;
        @(negedge clk);
        chk("r_ack", 32'(ack3), 32'd1);
        @(posedge clk); #1;
        rst_n3 = 1'b0;
        @(negedge clk);
        chk("r_rst_ack", 32'(ack3), 32'd0);
        chk("r_rst_resp", 32'(resp3), 32'(SCR1_MEM_RESP_NOTRDY));
        chk("r_rst_cs", 32'(cs3), 32'd0);
        @(posedge clk); #1;
        rst_n3 = 1'b1; req3 = 1'b0;
        nresp = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp3 != SCR1_MEM_RESP_NOTRDY) nresp++;
        end
        chk("r_noresp", 32'(nresp), 32'd0);
        @(posedge clk); #1;
        req3 = 1'b1; addr3 = c_base + 32'd8;
        @(negedge clk);
        chk("r_next_ack", 32'(ack3), 32'd1);
        @(posedge clk); #1;
        req3 = 1'b0;
        lat = 1;
        @(negedge clk);
        while (resp3 == SCR1_MEM_RESP_NOTRDY && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("r_next_lat", 32'(lat), 32'd3);
        chk("r_next_resp", 32'(resp3), 32'(SCR1_MEM_RESP_RDY_OK));
        chk("r_next_rdata", rdata3, 32'hA000_0002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_scr1_dmem_responder
`default_nettype wire

// File: doc/scr1_dmem_responder.md
Name: scr1_dmem_responder

Overview:
- Target-side endpoint of the core data-memory interface (req/req_ack/cmd/width/addr/wdata → rdata/resp).
- Sits between the core's dmem port and a single-port synchronous SRAM, used as a TCM or as a bench memory model.
- Accepts one request at a time, checks range and alignment, steers byte lanes, and returns the response after a programmable latency.

Parameters:
- SRAM_AWIDTH, 12, word-address width of the SRAM; capacity is 2**SRAM_AWIDTH 32-bit words.
- BASE_ADDR, 32'h0001_0000, byte base address of the window; must be aligned to the capacity.
- RESP_LATENCY, 1, cycles from the accept edge to the response cycle; legal range 1..4.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- dmem_req  in  1  request valid; held by the initiator until acknowledged.
- dmem_req_ack  out  1  request accepted this cycle.
- dmem_cmd  in  type_scr1_mem_cmd_e  RD or WR.
- dmem_width  in  type_scr1_mem_width_e  BYTE, HWORD or WORD.
- dmem_addr  in  32  byte address.
- dmem_wdata  in  32  write data, right-aligned.
- dmem_rdata  out  32  read data, right-aligned and zero-extended; valid only with RDY_OK on a RD.
- dmem_resp  out  type_scr1_mem_resp_e  NOTRDY, RDY_OK or RDY_ER.
- sram_cs  out  1  SRAM select.
- sram_we  out  1  SRAM write enable.
- sram_be  out  4  SRAM byte enables.
- sram_addr  out  SRAM_AWIDTH  SRAM word address.
- sram_wdata  out  32  lane-placed write data.
- sram_rdata  in  32  SRAM read data, valid one cycle after a cs read.

Behaviour:
- Reset: dmem_req_ack=0, dmem_resp=NOTRDY, dmem_rdata=0, sram_cs=0, sram_we=0, sram_be=0. FSM goes to IDLE; latency counter and captured fields are cleared.
- FSM states: IDLE, WAIT, RESP.
- dmem_req_ack = dmem_req & (state==IDLE | state==RESP). It is combinational, so back-to-back accepts are possible (a new request is accepted in the same cycle the previous response is presented).
- Accept cycle: the request is checked, and sram_* is driven combinationally in that same cycle when the request is good.
  - in_range = (addr & ~(4*2**SRAM_AWIDTH-1)) == BASE_ADDR.
  - aligned: HWORD needs addr[0]==0; WORD needs addr[1:0]==0; BYTE is always aligned.
  - Good request: sram_cs=1, sram_we=(cmd==WR), sram_addr=addr[SRAM_AWIDTH+1:2].
  - sram_be: BYTE → 4'b0001<<addr[1:0]; HWORD → 4'b0011<<addr[1:0]; WORD → 4'b1111.
  - sram_wdata: wdata shifted left by 8*addr[1:0]; unused lanes don't-care.
  - Bad request: no SRAM access; the error flag is latched.
- The accept latches cmd, width, addr[1:0], err and a counter loaded with RESP_LATENCY-1.
- Transitions:
  - After accept: counter==0 → RESP; otherwise → WAIT.
  - WAIT: decrement the counter each cycle; at 1 → RESP.
  - RESP: a new accept → same rule as from IDLE; no request → IDLE.
- Read data: sram_rdata is captured in the cycle after the accept (the latency-1 path is used directly from sram_rdata). It is shifted right by 8*addr[1:0] and masked to width (8 or 16 bits) or full 32.
- Response: in RESP, dmem_resp=RDY_ER if err, else RDY_OK, for exactly one cycle. dmem_rdata is 0 for writes and for errors. In all other cycles dmem_resp=NOTRDY.
- Latency: accept edge to response cycle is exactly RESP_LATENCY cycles, including for error responses.
- The initiator may drop or change dmem_req only after dmem_req_ack. Request fields are ignored outside the accept cycle.
- Reset mid-transaction: any pending response is discarded, no response is emitted, and an SRAM write issued in the accept cycle is not undone.
- Only one transaction is outstanding at a time; the response has no back-pressure (the initiator always takes it).

Decomposition:
- Package: use the existing type_scr1_mem_cmd_e, type_scr1_mem_width_e and type_scr1_mem_resp_e from the memif header. Add a local width-to-byte-enable function and SCR1_DMEM_RESP_LAT_MAX=4 as a shared constant.
- Sub-module: scr1_mem_lane_steer, purely combinational, covering be generation, write shift and read extract. It is reusable by an imem responder.
- The FSM and counter stay in the top module.

Test Plan:
- RESP_LATENCY=1: WR WORD 0x0001_0008 data 0xDEADBEEF, then RD WORD same address → ack on the request cycle; RDY_OK next cycle; read returns rdata=0xDEADBEEF; sram_be=4'b1111 on the write.
- WR BYTE 0x0001_0003 data 0x000000A5 → sram_be=4'b1000, sram_wdata[31:24]=0xA5. Then RD BYTE 0x0001_0003 → rdata=0x000000A5; RD WORD 0x0001_0000 → rdata[31:24]=0xA5.
- RD HWORD 0x0001_0001 (misaligned) and RD WORD 0x0002_0000 (out of range) → sram_cs stays 0; RDY_ER after RESP_LATENCY cycles; rdata=0.
- RESP_LATENCY=3: continuous dmem_req with 4 reads → acks at cycles 0, 3, 6, 9; RDY_OK at cycles 3, 6, 9, 12; dmem_resp is NOTRDY in between.
- Assert rst_n low in the WAIT cycle after accepting a RD → no response after deassertion; dmem_req_ack=0 during reset; the next request is serviced normally.
- Random mixed cmd/width/address traffic against a byte-array scoreboard, 10k transactions → zero data or response mismatches and fixed latency on every response.
